// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalization controller.
// This covers the top-level phase encoding, the LUT build sub-steps and the divider geometry.
package hist_eq_pkg;

    localparam int NBINS   = 256;
    localparam int PXW     = 8;
    localparam int DIV_NW  = 26;
    localparam int DIV_DW  = 17;
    localparam int DIV_LAT = 26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HIST,
        S_CDF,
        S_LUT,
        S_MAP,
        S_DONE
    } state_t;

    typedef enum logic {
        LS_ISSUE,
        LS_WAIT
    } lut_step_t;

    // The divider returns floor((2*num+den)/den). Halving that value gives the rounded LUT entry.
    function automatic logic [PXW-1:0] halve_clamp(input logic [DIV_NW-1:0] q);
        logic [DIV_NW-1:0] h;
        h = q >> 1;
        return (h > DIV_NW'(NBINS - 1)) ? PXW'(NBINS - 1) : h[PXW-1:0];
    endfunction

endpackage

// File: rtl/hist_eq_ctrl_if.sv
// Pixel-stream and status bundle of the histogram-equalization controller.
// The frame-buffer/display side is the master and the controller is the slave.
interface hist_eq_ctrl_if #(parameter int CW = 17);
    import hist_eq_pkg::*;

    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [PXW-1:0] in_pxl;
    logic           out_valid;
    logic           out_ready;
    logic [PXW-1:0] out_pxl;
    logic           pass;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cdf_min;

    modport master (
        output start, in_valid, in_pxl, out_ready,
        input  in_ready, out_valid, out_pxl, pass, busy, done, cdf_min
    );

    modport slave (
        input  start, in_valid, in_pxl, out_ready,
        output in_ready, out_valid, out_pxl, pass, busy, done, cdf_min
    );

endinterface

// File: rtl/hist_div.sv
// Restoring unsigned divider that produces one quotient bit per cycle.
// The first bit is resolved in the same cycle that start is sampled, so valid appears DIV_NW cycles later.
module hist_div
    import hist_eq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV_NW-1:0] num,
    input  logic [DIV_DW-1:0] den,
    output logic              busy,
    output logic              valid,
    output logic [DIV_NW-1:0] quo
);

    logic [DIV_DW-1:0] rem;
    logic [DIV_DW-1:0] dsr;
    logic [DIV_NW-1:0] dvd;
    logic [4:0]        cnt;

    logic [DIV_DW-1:0] src_rem;
    logic [DIV_DW-1:0] src_dsr;
    logic [DIV_NW-1:0] src_dvd;
    logic [DIV_DW:0]   trial;
    logic [DIV_DW-1:0] step_rem;
    logic [DIV_NW-1:0] step_dvd;

    // The dividend register shifts left and collects quotient bits in its LSBs.
    always_comb begin
        src_rem = start ? '0  : rem;
        src_dvd = start ? num : dvd;
        src_dsr = start ? den : dsr;
        trial   = {src_rem, src_dvd[DIV_NW-1]};
        if (trial >= {1'b0, src_dsr}) begin
            step_rem = DIV_DW'(trial - {1'b0, src_dsr});
            step_dvd = {src_dvd[DIV_NW-2:0], 1'b1};
        end else begin
            step_rem = trial[DIV_DW-1:0];
            step_dvd = {src_dvd[DIV_NW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            dsr   <= '0;
            dvd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                rem  <= step_rem;
                dvd  <= step_dvd;
                dsr  <= den;
                cnt  <= 5'd1;
                busy <= 1'b1;
            end else if (busy) begin
                rem <= step_rem;
                dvd <= step_dvd;
                cnt <= cnt + 5'd1;
                if (cnt == 5'(DIV_NW - 1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign quo = dvd;

endmodule

// File: rtl/hist_eq_ctrl.sv
// Two-pass histogram equalizer. It collects the histogram, builds the CDF in place,
// computes the remap LUT with a shared divider, then streams the frame through the LUT.
module hist_eq_ctrl
    import hist_eq_pkg::*;
#(
    parameter int NPIX = 76800,
    parameter int CW   = 17
) (
    input logic           clk,
    input logic           rst,
    hist_eq_ctrl_if.slave bus
);

    state_t    state;
    lut_step_t lut_step;

    logic [CW-1:0]  hist [NBINS];
    logic [PXW-1:0] lut  [NBINS];

    logic [CW-1:0]  pix_cnt;
    logic [CW-1:0]  run;
    logic [CW-1:0]  cdf_min_q;
    logic [PXW-1:0] bin;
    logic           min_found;
    logic           acc_en;
    logic           pass_q;
    logic           busy_q;
    logic           done_q;
    logic           out_valid_q;
    logic [PXW-1:0] out_pxl_q;

    logic           accept;
    logic           last_pix;
    logic           last_bin;
    logic [CW-1:0]  hist_rd;
    logic [CW-1:0]  run_next;
    logic [CW-1:0]  den;
    logic [CW-1:0]  diff;
    logic           den_zero;
    logic           below_min;

    logic              div_start;
    logic              div_busy;
    logic              div_valid;
    logic [DIV_NW-1:0] div_num;
    logic [DIV_NW-1:0] div_quo;

    logic           hist_we;
    logic [PXW-1:0] hist_wa;
    logic [CW-1:0]  hist_wd;
    logic           lut_we;
    logic [PXW-1:0] lut_wd;

    // In MAP, downstream backpressure gates acceptance. In HIST, acceptance depends only on registered state.
    assign bus.in_ready  = acc_en && (!pass_q || !out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_pxl   = out_pxl_q;
    assign bus.pass      = pass_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cdf_min   = cdf_min_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_pix  = (pix_cnt == CW'(NPIX - 1));
    assign last_bin  = (bin == PXW'(NBINS - 1));
    assign hist_rd   = hist[bin];
    assign run_next  = run + hist_rd;
    assign den       = CW'(NPIX) - cdf_min_q;
    assign den_zero  = (den == '0);
    assign below_min = (hist_rd < cdf_min_q);
    assign diff      = hist_rd - cdf_min_q;

    // Feed 2*num+den so that halving the quotient yields round-half-up with a 17-bit divisor.
    assign div_num   = DIV_NW'(diff) * DIV_NW'(510) + DIV_NW'(den);
    assign div_start = (state == S_LUT) && (lut_step == LS_ISSUE) && !den_zero && !below_min && !div_busy;

    hist_div u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (DIV_DW'(den)),
        .busy  (div_busy),
        .valid (div_valid),
        .quo   (div_quo)
    );

    // The single histogram write port is shared by the clear, the count and the in-place prefix sum.
    always_comb begin
        hist_we = 1'b0;
        hist_wa = bin;
        hist_wd = '0;
        case (state)
            S_CLEAR: hist_we = 1'b1;
            S_HIST: begin
                hist_we = accept;
                hist_wa = bus.in_pxl;
                hist_wd = hist[bus.in_pxl] + CW'(1);
            end
            S_CDF: begin
                hist_we = 1'b1;
                hist_wd = run_next;
            end
            default: ;
        endcase
    end

    always_comb begin
        lut_we = 1'b0;
        lut_wd = '0;
        if (state == S_LUT) begin
            if (lut_step == LS_ISSUE) begin
                if (den_zero) begin
                    lut_we = 1'b1;
                    lut_wd = bin;
                end else if (below_min) begin
                    lut_we = 1'b1;
                end
            end else if (div_valid) begin
                lut_we = 1'b1;
                lut_wd = halve_clamp(div_quo);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hist_we) hist[hist_wa] <= hist_wd;
        if (lut_we)  lut[bin]      <= lut_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            lut_step    <= LS_ISSUE;
            pix_cnt     <= '0;
            run         <= '0;
            cdf_min_q   <= '0;
            bin         <= '0;
            min_found   <= 1'b0;
            acc_en      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pxl_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        bin    <= '0;
                        state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    bin <= bin + PXW'(1);
                    if (last_bin) begin
                        acc_en  <= 1'b1;
                        pass_q  <= 1'b0;
                        pix_cnt <= '0;
                        state   <= S_HIST;
                    end
                end
                S_HIST: begin
                    if (accept) begin
                        if (last_pix) begin
                            pix_cnt   <= '0;
                            acc_en    <= 1'b0;
                            run       <= '0;
                            min_found <= 1'b0;
                            bin       <= '0;
                            state     <= S_CDF;
                        end else begin
                            pix_cnt <= pix_cnt + CW'(1);
                        end
                    end
                end
                S_CDF: begin
                    run <= run_next;
                    bin <= bin + PXW'(1);
                    if (!min_found && run_next != '0) begin
                        cdf_min_q <= run_next;
                        min_found <= 1'b1;
                    end
                    if (last_bin) begin
                        lut_step <= LS_ISSUE;
                        state    <= S_LUT;
                    end
                end
                S_LUT: begin
                    if (lut_we) begin
                        bin      <= bin + PXW'(1);
                        lut_step <= LS_ISSUE;
                        if (last_bin) begin
                            acc_en  <= 1'b1;
                            pass_q  <= 1'b1;
                            pix_cnt <= '0;
                            state   <= S_MAP;
                        end
                    end else if (div_start) begin
                        lut_step <= LS_WAIT;
                    end
                end
                S_MAP: begin
                    if (accept) begin
                        out_pxl_q   <= lut[bus.in_pxl];
                        out_valid_q <= 1'b1;
                        if (last_pix) begin
                            pix_cnt <= '0;
                            acc_en  <= 1'b0;
                        end else begin
                            pix_cnt <= pix_cnt + CW'(1);
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    // Leave only once every accepted pixel has been handed downstream.
                    if (!acc_en && (!out_valid_q || bus.out_ready)) begin
                        pass_q <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/hist_eq_ctrl.md
# hist_eq_ctrl

Two-pass histogram-equalization controller for the post-decode grayscale path. Pass 1 collects a 256-bin histogram of a frame streamed from the frame buffer. The block then builds the CDF, finds `cdf_min` and computes a 256-entry remap LUT with a shared sequential divider. Pass 2 streams the same frame back through the LUT to the display/output path.

## Interface
- `NPIX`, 76800, pixels per frame (320x240); must be ≥1 and ≤131071.
- `CW`, 17, bin/CDF counter width; must hold `NPIX`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a frame when idle, ignored while `busy`.
- `in_valid`  in  1  pixel valid from frame buffer.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `in_pxl`  in  8  grayscale pixel.
- `out_valid`  out  1  equalized pixel valid.
- `out_ready`  in  1  downstream accept.
- `out_pxl`  out  8  equalized pixel.
- `pass`  out  1  0 = frame buffer must send pass 1; 1 = pass 2. Meaningful only while `in_ready`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last pass-2 pixel leaves.
- `cdf_min`  out  CW  CDF value of the lowest occupied bin; holds until the next `cdf_min` capture.

## Operation
- States: IDLE, CLEAR, HIST, CDF, LUT, MAP, DONE.
- IDLE: `start` goes to CLEAR.
- CLEAR: zeroes `hist[0..255]` over 256 cycles, then goes to HIST.
- HIST: `in_ready=1`, `pass=0`. Each accepted pixel does `hist[in_pxl]++`. Back-to-back same-value pixels must count correctly; use a bypass or read-modify-write forward. After `NPIX` accepts, go to CDF.
- CDF: one bin per cycle, in place: `run += hist[i]; hist[i] = run`. The first bin with `run != 0` latches `cdf_min`. After 256 cycles, go to LUT.
- LUT: for i = 0..255:
  - `num = (hist[i]-cdf_min)*255` (25 bits); `den = NPIX-cdf_min`.
  - Bins with `hist[i] < cdf_min` (below the first occupied bin) get `lut[i]=0`.
  - Otherwise `lut[i] = floor((2*num+den)/(2*den))`, i.e. round half up, clamped to 255.
  - If `den==0` (single-valued frame), `lut[i]=i` (identity) and the divider is skipped.
  - Then go to MAP.
- MAP: `pass=1`, `in_ready = !out_valid || out_ready`. An accepted pixel produces `out_pxl = lut[in_pxl]`. After `NPIX` accepts and the final output is taken, go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Counters: pixel counter is CW bits and wraps to 0 at phase exit; bin index is 8 bits.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_pxl=0`, `pass=0`, `busy=0`, `done=0`, `cdf_min=0`; state IDLE.
- Histogram and LUT contents are not reset; CLEAR and LUT overwrite them.
- `rst` mid-frame aborts to IDLE immediately; the next `start` runs a full clean frame.
- MAP latency: output registered, `out_valid` rises 1 cycle after the accept.
  - Throughput is 1 pixel/cycle with `out_ready=1`.
  - While `out_valid && !out_ready`: `out_pxl` holds stable and `in_ready=0`; no pixel is dropped or duplicated.
- `start` coincident with DONE or while `busy` is ignored.
- Phase cycle counts:
  - CLEAR: 256.
  - HIST: ≥ `NPIX`.
  - CDF: 256.
  - LUT: ≤ 256·(DIV_LAT+2), where DIV_LAT = 26.
  - MAP: ≥ `NPIX`.
- `busy` and `pass` are registered, with no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `hist_eq_pkg`: state enum, `NBINS=256`, `PXW=8`, `DIV_NW=26`, `DIV_DW=17`.
- Sub-module `hist_div`: restoring divider, 1 quotient bit/cycle.
  - Ports: `start`, `num[25:0]`, `den[16:0]`, `busy`, `valid`, `quo[25:0]`.
  - Latency DIV_LAT = 26 cycles from `start` to `valid`.
- Storage: `hist` as CW×256 and `lut` as 8×256 register arrays with a single write port each.

## Test plan
- `NPIX=256`, values 0..255 once each: `cdf_min=1`, `lut[v]=v`, output equals input, `done` pulses once.
- `NPIX=4`, pass 1 = 10,10,200,200: `cdf_min=2`, `lut[10]=0`, `lut[200]=255`; pass 2 = 200,10 gives 255,0.
- `NPIX=3`, values 0,1,2: `cdf_min=1`, `den=2`, `lut[1]=128` (half rounds up), `lut[2]=255`.
- `NPIX=16`, all pixels 42: `den=0`, identity LUT, every output is 42, no divider start.
- `NPIX=8`, back-to-back pixel 7 ×8 then ramp pass 2, with `out_ready` low 5 cycles mid-MAP: `out_pxl` stable, `in_ready=0` during the stall, 8 outputs total.
- Frame run, then `rst` after 3 HIST accepts, then `start` with the `NPIX=4` frame above: results identical to that test; `start` pulsed during LUT is ignored.
